// File: rtl/ysyx_22050598_pkg.sv
// Shared types for the memory arbiter: FSM states, requester owner, access size codes.
package ysyx_22050598_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  typedef enum logic {OwnIf, OwnLs} owner_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  localparam logic [7:0] IF_LEN = 8'd4;

  function automatic logic [7:0] size_bytes(input logic [1:0] size);
    logic [7:0] bytes;
    unique case (size)
      SIZE_B:  bytes = 8'd1;
      SIZE_H:  bytes = 8'd2;
      SIZE_W:  bytes = 8'd4;
      default: bytes = 8'd8;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/ysyx_22050598_mem_timer.sv
// Request timeout counter; only exists when YSYX_22050598_MEM_TIMEOUT_EN is defined.
`ifdef YSYX_22050598_MEM_TIMEOUT_EN
module ysyx_22050598_mem_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  // Fires on the last counting cycle so the response lands TIMEOUT edges after accept.
  assign expired_o = inc_i && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/ysyx_22050598_mem_arbiter.sv
// Two-requester (fetch, load/store) single-outstanding memory arbiter, load/store wins ties.
// Optional request timeout enabled by YSYX_22050598_MEM_TIMEOUT_EN.
module ysyx_22050598_mem_arbiter
  import ysyx_22050598_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        if_req_valid_i,
  output logic        if_req_ready_o,
  input  logic [63:0] if_addr_i,
  output logic        if_rsp_valid_o,
  output logic [63:0] if_rdata_o,
  output logic        if_rsp_err_o,

  input  logic        ls_req_valid_i,
  output logic        ls_req_ready_o,
  input  logic        ls_wen_i,
  input  logic [63:0] ls_addr_i,
  input  logic [63:0] ls_wdata_i,
  input  logic [1:0]  ls_type_i,
  output logic        ls_rsp_valid_o,
  output logic [63:0] ls_rdata_o,
  output logic        ls_rsp_err_o,

  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_wen_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_len_o,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i
);

  state_e      state_q;
  owner_e      owner_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        wen_q;
  logic [7:0]  len_q;

  logic ls_grant;
  logic if_grant;

  assign ls_grant = (state_q == StIdle) && ls_req_valid_i;
  assign if_grant = (state_q == StIdle) && if_req_valid_i && !ls_req_valid_i;

  // Gated by rst_n so nothing is advertised while the block is held in reset.
  assign ls_req_ready_o = ls_grant && rst_n;
  assign if_req_ready_o = if_grant && rst_n;

`ifdef YSYX_22050598_MEM_TIMEOUT_EN
  logic err_q;
  logic timeout_hit;

  ysyx_22050598_mem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (ls_grant || if_grant),
    .inc_i     ((state_q == StReq) || (state_q == StWait)),
    .expired_o (timeout_hit)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= OwnIf;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wen_q   <= 1'b0;
      len_q   <= '0;
`ifdef YSYX_22050598_MEM_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ls_grant) begin
            owner_q <= OwnLs;
            addr_q  <= ls_addr_i;
            wdata_q <= ls_wdata_i;
            wen_q   <= ls_wen_i;
            len_q   <= size_bytes(ls_type_i);
            rdata_q <= '0;
`ifdef YSYX_22050598_MEM_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            state_q <= StReq;
          end else if (if_grant) begin
            owner_q <= OwnIf;
            addr_q  <= if_addr_i;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            len_q   <= IF_LEN;
            rdata_q <= '0;
`ifdef YSYX_22050598_MEM_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            state_q <= StReq;
          end
        end
        StReq: begin
          if (mem_ready_i && mem_rvalid_i) begin
            rdata_q <= wen_q ? '0 : mem_rdata_i;
            state_q <= StResp;
          end else if (mem_ready_i) begin
            state_q <= StWait;
`ifdef YSYX_22050598_MEM_TIMEOUT_EN
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= StResp;
`endif
          end
        end
        StWait: begin
          if (mem_rvalid_i) begin
            rdata_q <= wen_q ? '0 : mem_rdata_i;
            state_q <= StResp;
`ifdef YSYX_22050598_MEM_TIMEOUT_EN
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= StResp;
`endif
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_valid_o = (state_q == StReq);
  assign mem_wen_o   = mem_valid_o && wen_q;
  assign mem_addr_o  = mem_valid_o ? addr_q  : '0;
  assign mem_wdata_o = mem_valid_o ? wdata_q : '0;
  assign mem_len_o   = mem_valid_o ? len_q   : '0;

  assign if_rsp_valid_o = (state_q == StResp) && (owner_q == OwnIf);
  assign ls_rsp_valid_o = (state_q == StResp) && (owner_q == OwnLs);
  assign if_rdata_o     = if_rsp_valid_o ? rdata_q : '0;
  assign ls_rdata_o     = ls_rsp_valid_o ? rdata_q : '0;

`ifdef YSYX_22050598_MEM_TIMEOUT_EN
  assign if_rsp_err_o = if_rsp_valid_o && err_q;
  assign ls_rsp_err_o = ls_rsp_valid_o && err_q;
`else
  assign if_rsp_err_o = 1'b0;
  assign ls_rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050598_mem_arbiter.sv
// Self-checking bench for ysyx_22050598_mem_arbiter with a configurable memory responder.
module tb_ysyx_22050598_mem_arbiter;

  localparam int unsigned TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid, ls_rsp_err;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [1:0]  ls_type;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_len;

  int n_cmp;
  int n_bad;

  int          cfg_rdy_dly  = 0;
  int          cfg_rv_dly   = 0;
  bit          cfg_silent   = 0;
  bit          cfg_stray    = 0;
  bit          cfg_force_rv = 0;
  logic [63:0] cfg_data     = '0;

  ysyx_22050598_mem_arbiter #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req_valid_i (if_req_valid),
    .if_req_ready_o (if_req_ready),
    .if_addr_i      (if_addr),
    .if_rsp_valid_o (if_rsp_valid),
    .if_rdata_o     (if_rdata),
    .if_rsp_err_o   (if_rsp_err),
    .ls_req_valid_i (ls_req_valid),
    .ls_req_ready_o (ls_req_ready),
    .ls_wen_i       (ls_wen),
    .ls_addr_i      (ls_addr),
    .ls_wdata_i     (ls_wdata),
    .ls_type_i      (ls_type),
    .ls_rsp_valid_o (ls_rsp_valid),
    .ls_rdata_o     (ls_rdata),
    .ls_rsp_err_o   (ls_rsp_err),
    .mem_valid_o    (mem_valid),
    .mem_ready_i    (mem_ready),
    .mem_wen_o      (mem_wen),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_len_o      (mem_len),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side: ready after cfg_rdy_dly REQ cycles, rvalid cfg_rv_dly cycles after ready.
  initial begin : mem_model
    bit hs;
    int cnt;
    int rv_cnt;
    hs = 0; cnt = 0; rv_cnt = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      if (!rst_n) begin
        hs = 0; cnt = 0;
      end else begin
        if (if_rsp_valid || ls_rsp_valid) begin
          hs = 0; cnt = 0;
        end
        if (mem_valid && !hs) begin
          if (cnt >= cfg_rdy_dly) begin
            mem_ready = 1'b1; hs = 1; rv_cnt = 0;
            if (cfg_rv_dly == 0 && !cfg_silent) begin
              mem_rvalid = 1'b1; mem_rdata = cfg_data;
            end
          end else begin
            cnt++;
          end
        end else if (hs) begin
          rv_cnt++;
          if (rv_cnt == cfg_rv_dly && !cfg_silent) begin
            mem_rvalid = 1'b1; mem_rdata = cfg_data;
          end
        end else if (cfg_stray) begin
          mem_rvalid = 1'($urandom_range(0, 1));
        end
      end
      if (cfg_force_rv) begin
        mem_rvalid = 1'b1; mem_rdata = cfg_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Drives one request from IDLE and records what the memory side and requester observe.
  task automatic issue(input bit is_ls, input bit wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [1:0] typ,
                       output bit rdy_ok, output logic [7:0] len, output logic o_wen,
                       output logic [63:0] o_addr, output logic [63:0] o_wdata,
                       output bit stable, output int nreq, output int lat,
                       output bit got_if, output bit got_ls, output logic [63:0] rdata,
                       output logic err, output bit one_pulse);
    if (is_ls) begin
      ls_req_valid = 1'b1; ls_wen = wen; ls_addr = addr; ls_wdata = wdata; ls_type = typ;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    #1;
    rdy_ok = is_ls ? (ls_req_ready === 1'b1 && if_req_ready === 1'b0)
                   : (if_req_ready === 1'b1 && ls_req_ready === 1'b0);
    tick();
    ls_req_valid = 1'b0; if_req_valid = 1'b0;
    ls_addr = {$urandom, $urandom}; ls_wdata = {$urandom, $urandom};
    if_addr = {$urandom, $urandom}; ls_type = 2'($urandom_range(0, 3));
    len = mem_len; o_wen = mem_wen; o_addr = mem_addr; o_wdata = mem_wdata;
    stable = (mem_valid === 1'b1);
    nreq = 0; lat = -1; got_if = 0; got_ls = 0; rdata = 'x; err = 'x; one_pulse = 0;
    for (int k = 0; k < 60; k++) begin
      if (if_rsp_valid === 1'b1 || ls_rsp_valid === 1'b1) begin
        lat = k; got_if = if_rsp_valid; got_ls = ls_rsp_valid;
        rdata = is_ls ? ls_rdata : if_rdata;
        err = is_ls ? ls_rsp_err : if_rsp_err;
        break;
      end
      if (mem_valid === 1'b1) begin
        nreq++;
        if (mem_len !== len || mem_wen !== o_wen || mem_addr !== o_addr ||
            mem_wdata !== o_wdata) stable = 0;
      end
      tick();
    end
    if (lat >= 0) begin
      tick();
      one_pulse = (if_rsp_valid === 1'b0 && ls_rsp_valid === 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    ls_req_valid = 1'b1; if_req_valid = 1'b1;
    #1;
    n_cmp++;
    if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err,
         mem_valid, mem_wen} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 00000000", {if_req_ready, ls_req_ready,
               if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err, mem_valid, mem_wen});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_len, if_rdata, ls_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h required 0",
               {mem_addr, mem_wdata, mem_len, if_rdata, ls_rdata});
    end
    ls_req_valid = 1'b0; if_req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({mem_valid, if_rsp_valid, ls_rsp_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_release_idle: got %b required 000",
               {mem_valid, if_rsp_valid, ls_rsp_valid});
    end
  endtask

  task automatic test_load_word();
    bit rdy_ok, stable, got_if, got_ls, one_pulse;
    logic [7:0] len; logic wen, err; logic [63:0] a, wd, rd; int nreq, lat;
    cfg_rdy_dly = 0; cfg_rv_dly = 1; cfg_data = 64'h11223344; cfg_silent = 0; cfg_stray = 0;
    issue(1, 0, 64'h80000004, 64'h0, 2'b10, rdy_ok, len, wen, a, wd, stable, nreq, lat,
          got_if, got_ls, rd, err, one_pulse);
    n_cmp++;
    if ({rdy_ok, got_ls, got_if, err, one_pulse, stable} !== 6'b110011) begin
      n_bad++;
      $display("FAIL ldw_flags: got %b required 110011",
               {rdy_ok, got_ls, got_if, err, one_pulse, stable});
    end
    n_cmp++;
    if ({len, wen, a} !== {8'd4, 1'b0, 64'h80000004}) begin
      n_bad++;
      $display("FAIL ldw_req: got len=%0d wen=%b addr=%h required len=4 wen=0 addr=80000004",
               len, wen, a);
    end
    n_cmp++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL ldw_latency: got %0d required 2", lat);
    end
    n_cmp++;
    if (rd !== 64'h11223344) begin
      n_bad++; $display("FAIL ldw_rdata: got %h required 11223344", rd);
    end
  endtask

  task automatic test_fast_resp();
    bit rdy_ok, stable, got_if, got_ls, one_pulse;
    logic [7:0] len; logic wen, err; logic [63:0] a, wd, rd; int nreq, lat;
    cfg_rdy_dly = 0; cfg_rv_dly = 0; cfg_data = 64'h0000_0013_DEAD_BEEF;
    issue(0, 0, 64'h80000010, 64'h0, 2'b00, rdy_ok, len, wen, a, wd, stable, nreq, lat,
          got_if, got_ls, rd, err, one_pulse);
    n_cmp++;
    if ({lat, nreq} !== {32'd1, 32'd1}) begin
      n_bad++; $display("FAIL fast_timing: got lat=%0d req=%0d required lat=1 req=1", lat, nreq);
    end
    n_cmp++;
    if ({rdy_ok, got_if, got_ls, len, wen, wd, rd} !==
        {1'b1, 1'b1, 1'b0, 8'd4, 1'b0, 64'h0, 64'h0000_0013_DEAD_BEEF}) begin
      n_bad++;
      $display("FAIL fast_if: got rdy=%b if=%b ls=%b len=%0d wen=%b wd=%h rd=%h",
               rdy_ok, got_if, got_ls, len, wen, wd, rd);
    end
  endtask

  task automatic test_store_stall();
    bit rdy_ok, stable, got_if, got_ls, one_pulse;
    logic [7:0] len; logic wen, err; logic [63:0] a, wd, rd; int nreq, lat;
    cfg_rdy_dly = 5; cfg_rv_dly = 1; cfg_data = 64'h5555_6666_7777_8888;
    issue(1, 1, 64'h80002003, 64'hABABABABABABABAB, 2'b00, rdy_ok, len, wen, a, wd, stable,
          nreq, lat, got_if, got_ls, rd, err, one_pulse);
    n_cmp++;
    if ({stable, nreq} !== {1'b1, 32'd6}) begin
      n_bad++; $display("FAIL st_stable: got stable=%b req=%0d required 1/6", stable, nreq);
    end
    n_cmp++;
    if ({len, wen, a, wd} !== {8'd1, 1'b1, 64'h80002003, 64'hABABABABABABABAB}) begin
      n_bad++;
      $display("FAIL st_req: got len=%0d wen=%b addr=%h wd=%h", len, wen, a, wd);
    end
    n_cmp++;
    if ({got_ls, got_if, one_pulse, rd} !== {3'b101, 64'h0}) begin
      n_bad++;
      $display("FAIL st_rsp: got ls=%b if=%b pulse=%b rd=%h required 1 0 1 0",
               got_ls, got_if, one_pulse, rd);
    end
    n_cmp++;
    if (lat !== 7) begin
      n_bad++; $display("FAIL st_latency: got %0d required 7", lat);
    end
  endtask

  task automatic test_arbitration();
    bit found, blocked_ok;
    cfg_rdy_dly = 1; cfg_rv_dly = 1; cfg_data = 64'h0123_4567_89AB_CDEF;
    ls_req_valid = 1'b1; ls_wen = 1'b0; ls_addr = 64'h80001000; ls_type = 2'b11;
    if_req_valid = 1'b1; if_addr = 64'h80000000;
    #1;
    n_cmp++;
    if ({ls_req_ready, if_req_ready} !== 2'b10) begin
      n_bad++; $display("FAIL arb_tie: got ls/if ready %b required 10",
                        {ls_req_ready, if_req_ready});
    end
    tick();
    ls_req_valid = 1'b0;
    n_cmp++;
    if ({mem_valid, mem_len, mem_addr} !== {1'b1, 8'd8, 64'h80001000}) begin
      n_bad++; $display("FAIL arb_ls_first: got v=%b len=%0d addr=%h", mem_valid, mem_len,
                        mem_addr);
    end
    found = 0; blocked_ok = 1;
    for (int k = 0; k < 20; k++) begin
      if (if_req_ready !== 1'b0 || if_rsp_valid !== 1'b0) blocked_ok = 0;
      if (ls_rsp_valid === 1'b1) begin
        found = 1; break;
      end
      tick();
    end
    n_cmp++;
    if ({found, blocked_ok, ls_rdata} !== {2'b11, 64'h0123_4567_89AB_CDEF}) begin
      n_bad++; $display("FAIL arb_ls_rsp: got found=%b blocked=%b rd=%h", found, blocked_ok,
                        ls_rdata);
    end
    tick();
    n_cmp++;
    if (if_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL arb_if_grant: got %b required 1", if_req_ready);
    end
    tick();
    if_req_valid = 1'b0;
    n_cmp++;
    if ({mem_valid, mem_len, mem_addr, mem_wen} !== {1'b1, 8'd4, 64'h80000000, 1'b0}) begin
      n_bad++; $display("FAIL arb_if_req: got v=%b len=%0d addr=%h wen=%b", mem_valid,
                        mem_len, mem_addr, mem_wen);
    end
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (if_rsp_valid === 1'b1) begin
        found = 1; break;
      end
      tick();
    end
    n_cmp++;
    if ({found, if_rdata} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin
      n_bad++; $display("FAIL arb_if_rsp: got found=%b rd=%h", found, if_rdata);
    end
    tick();
  endtask

  task automatic test_random();
    bit rdy_ok, stable, got_if, got_ls, one_pulse;
    logic [7:0] len; logic wen, err; logic [63:0] a, wd, rd; int nreq, lat;
    bit is_ls, st; logic [1:0] typ; logic [63:0] addr, wdata, data;
    logic [7:0] exp_len; logic [63:0] exp_rd;
    cfg_stray = 1;
    for (int t = 0; t < 40; t++) begin
      is_ls = 1'($urandom_range(0, 1)); st = is_ls && ($urandom_range(0, 1) == 1);
      typ = 2'($urandom_range(0, 3));
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; data = {$urandom, $urandom};
      cfg_rdy_dly = $urandom_range(0, 3); cfg_rv_dly = $urandom_range(0, 3); cfg_data = data;
      exp_len = is_ls ? (8'd1 << typ) : 8'd4;
      exp_rd  = st ? 64'h0 : data;
      issue(is_ls, st, addr, wdata, typ, rdy_ok, len, wen, a, wd, stable, nreq, lat,
            got_if, got_ls, rd, err, one_pulse);
      n_cmp++;
      if ({rdy_ok, got_ls, got_if, err, one_pulse, stable} !==
          {1'b1, is_ls, !is_ls, 1'b0, 1'b1, 1'b1}) begin
        n_bad++; $display("FAIL rnd_flags[%0d]: got %b required %b", t,
                          {rdy_ok, got_ls, got_if, err, one_pulse, stable},
                          {1'b1, is_ls, !is_ls, 1'b0, 1'b1, 1'b1});
      end
      n_cmp++;
      if ({len, wen, a} !== {exp_len, st, addr}) begin
        n_bad++; $display("FAIL rnd_req[%0d]: got len=%0d wen=%b addr=%h required %0d %b %h",
                          t, len, wen, a, exp_len, st, addr);
      end
      if (!is_ls || st) begin
        n_cmp++;
        if (wd !== (st ? wdata : 64'h0)) begin
          n_bad++; $display("FAIL rnd_wdata[%0d]: got %h required %h", t, wd,
                            st ? wdata : 64'h0);
        end
      end
      n_cmp++;
      if (lat !== cfg_rdy_dly + cfg_rv_dly + 1 || nreq !== cfg_rdy_dly + 1) begin
        n_bad++; $display("FAIL rnd_timing[%0d]: got lat=%0d req=%0d required %0d %0d", t,
                          lat, nreq, cfg_rdy_dly + cfg_rv_dly + 1, cfg_rdy_dly + 1);
      end
      n_cmp++;
      if (rd !== exp_rd) begin
        n_bad++; $display("FAIL rnd_rdata[%0d]: got %h required %h", t, rd, exp_rd);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    cfg_stray = 0;
  endtask

  task automatic test_reset_mid();
    bit rdy_ok, stable, got_if, got_ls, one_pulse, quiet;
    logic [7:0] len; logic wen, err; logic [63:0] a, wd, rd; int nreq, lat;
    cfg_rdy_dly = 0; cfg_rv_dly = 30; cfg_data = 64'hFEED_FACE_0BAD_F00D;
    ls_req_valid = 1'b1; ls_wen = 1'b0; ls_addr = 64'h80003000; ls_type = 2'b11;
    tick();
    ls_req_valid = 1'b0;
    tick();
    n_cmp++;
    if ({mem_valid, ls_rsp_valid} !== 2'b00) begin
      n_bad++; $display("FAIL rst_mid_wait: got v/rsp %b required 00", {mem_valid, ls_rsp_valid});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_valid, mem_wen, mem_addr,
         mem_len, ls_rdata, if_rdata} !== '0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got nonzero v=%b addr=%h len=%0d", mem_valid,
                        mem_addr, mem_len);
    end
    tick();
    rst_n = 1'b1;
    cfg_force_rv = 1;
    tick();
    cfg_force_rv = 0;
    quiet = 1;
    repeat (6) begin
      tick();
      if ({if_rsp_valid, ls_rsp_valid, mem_valid} !== 3'b000) quiet = 0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_no_rsp: got activity after release required none");
    end
    cfg_rv_dly = 1; cfg_data = 64'h0000_0000_0000_00A5;
    issue(1, 0, 64'h80003008, 64'h0, 2'b00, rdy_ok, len, wen, a, wd, stable, nreq, lat,
          got_if, got_ls, rd, err, one_pulse);
    n_cmp++;
    if ({rdy_ok, got_ls, len, lat, rd} !== {2'b11, 8'd1, 32'd2, 64'hA5}) begin
      n_bad++; $display("FAIL rst_mid_recover: got rdy=%b ls=%b len=%0d lat=%0d rd=%h",
                        rdy_ok, got_ls, len, lat, rd);
    end
  endtask

`ifdef YSYX_22050598_MEM_TIMEOUT_EN
  task automatic test_timeout();
    bit rdy_ok, stable, got_if, got_ls, one_pulse;
    logic [7:0] len; logic wen, err; logic [63:0] a, wd, rd; int nreq, lat;
    cfg_rdy_dly = 0; cfg_rv_dly = 1; cfg_silent = 1; cfg_data = 64'h1;
    issue(1, 0, 64'h80004000, 64'h0, 2'b10, rdy_ok, len, wen, a, wd, stable, nreq, lat,
          got_if, got_ls, rd, err, one_pulse);
    n_cmp++;
    if ({lat, got_ls, err, rd} !== {32'd8, 1'b1, 1'b1, 64'h0}) begin
      n_bad++; $display("FAIL to_wait: got lat=%0d ls=%b err=%b rd=%h required 8 1 1 0",
                        lat, got_ls, err, rd);
    end
    cfg_rdy_dly = 100;
    issue(0, 0, 64'h80004100, 64'h0, 2'b00, rdy_ok, len, wen, a, wd, stable, nreq, lat,
          got_if, got_ls, rd, err, one_pulse);
    n_cmp++;
    if ({lat, nreq, got_if, err, rd} !== {32'd8, 32'd8, 1'b1, 1'b1, 64'h0}) begin
      n_bad++; $display("FAIL to_req: got lat=%0d req=%0d if=%b err=%b rd=%h", lat, nreq,
                        got_if, err, rd);
    end
    cfg_rdy_dly = 0; cfg_rv_dly = 0; cfg_silent = 0; cfg_data = 64'h77;
    issue(1, 0, 64'h80004200, 64'h0, 2'b11, rdy_ok, len, wen, a, wd, stable, nreq, lat,
          got_if, got_ls, rd, err, one_pulse);
    n_cmp++;
    if ({lat, got_ls, err, rd} !== {32'd1, 1'b1, 1'b0, 64'h77}) begin
      n_bad++; $display("FAIL to_after: got lat=%0d ls=%b err=%b rd=%h", lat, got_ls, err, rd);
    end
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_type = 2'b00;
    test_reset();
    test_load_word();
    test_fast_resp();
    test_store_stall();
    test_arbitration();
    test_random();
    test_reset_mid();
`ifdef YSYX_22050598_MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
